rr_mux_collector: RTL and testbench

//  Round-robin N:1 collector: gathers words from 2**SEL_WIDTH valid/ready producer channels into one

---
 rtl/dpc_mux_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 36 +++
 rtl/rr_mux_collector.sv | 77 +++++++
 tb/tb_rr_mux_collector.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dpc_mux_pkg.sv
// Shared types and helpers for the round-robin collector.
// Combinational helpers only, no latency.
// No flow control of its own.
package dpc_mux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } coll_state_t;

    // Modulo-2**sel_width increment used to advance the round-robin pointer.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned sel_width);
        return (idx + 32'd1) & ((32'd1 << sel_width) - 32'd1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: first requester at or above ptr, wrapping.
// Purely combinational, zero latency.
// No flow control; grant is all-zero when no request is present.
module rr_priority_pick #(
    parameter int SEL_WIDTH = 2
) (
    input  logic [(2**SEL_WIDTH)-1:0] req,
    input  logic [SEL_WIDTH-1:0]      ptr,
    output logic [(2**SEL_WIDTH)-1:0] grant,
    output logic [SEL_WIDTH-1:0]      idx
);

    localparam int CHANNELS = 2**SEL_WIDTH;

    logic [2*CHANNELS-1:0] dbl;
    logic [CHANNELS-1:0]   rot;
    logic [SEL_WIDTH-1:0]  off;

    always_comb begin
        // Rotate so ptr lands at bit 0, encode the lowest set bit, rotate back by adding ptr.
        dbl = {req, req} >> ptr;
        rot = dbl[CHANNELS-1:0];
        off = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_WIDTH'(i);
            end
        end
        idx   = ptr + off;
        grant = '0;
        if (|req) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_collector.sv
// Round-robin N:1 collector into one registered stream tagged with the source channel.
// One cycle from input handshake to out_valid; 1 word/cycle with out_ready held high.
// Stall holds out_data/out_sel, drops all in_ready and freezes the pointer; out_ready->in_ready is combinational.
module rr_mux_collector
    import dpc_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                                Clk,
    input  logic                                Rst_n,
    input  logic [(2**SEL_WIDTH)-1:0]           in_valid,
    input  logic [(2**SEL_WIDTH)*DATA_WIDTH-1:0] in_data,
    output logic [(2**SEL_WIDTH)-1:0]           in_ready,
    output logic                                out_valid,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [SEL_WIDTH-1:0]                out_sel,
    input  logic                                out_ready
);

    localparam int CHANNELS = 2**SEL_WIDTH;

    coll_state_t             state_q;
    coll_state_t             state_d;
    logic [SEL_WIDTH-1:0]    ptr_q;
    logic [CHANNELS-1:0]     grant;
    logic [SEL_WIDTH-1:0]    pick_idx;
    logic                    load_en;
    logic                    any_vld;
    logic                    load;
    logic [DATA_WIDTH-1:0]   words [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_words
        assign words[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_pick #(
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (pick_idx)
    );

    assign out_valid = (state_q == FULL);
    assign load_en   = !out_valid || out_ready;
    assign any_vld   = |in_valid;
    assign load      = load_en && any_vld;
    assign in_ready  = load ? grant : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL:  if (out_ready && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= EMPTY;
            ptr_q    <= '0;
            out_data <= '0;
            out_sel  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                out_data <= words[pick_idx];
                out_sel  <= pick_idx;
                ptr_q    <= SEL_WIDTH'(rr_next(32'(pick_idx), SEL_WIDTH));
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_collector.sv
// Directed vector table plus randomized traffic checked against a queue-free behavioural model.
module tb_rr_mux_collector;

    logic        Clk;
    logic        Rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int vectors;
    int miscompares;

    // behavioural model state
    logic        m_valid;
    logic [7:0]  m_data;
    int          m_sel;
    int          m_ptr;

    typedef struct {
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;
        logic       ovld;
        logic [7:0] odat;
        logic [1:0] osel;
    } vec_t;

    vec_t tbl [14];

    localparam logic [31:0] FIX_DATA = {8'h44, 8'hA5, 8'h22, 8'h11};

    rr_mux_collector #(
        .DATA_WIDTH (8),
        .SEL_WIDTH  (2)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare in_ready before the edge and registered outputs after it.
    task automatic apply_vec(input vec_t v);
        @(negedge Clk);
        in_valid  = v.vld;
        in_data   = FIX_DATA;
        out_ready = v.ordy;
        #1;
        check("tbl_in_ready", 32'(in_ready), 32'(v.rdy));
        @(posedge Clk);
        #1;
        check("tbl_out_valid", 32'(out_valid), 32'(v.ovld));
        check("tbl_out_data", 32'(out_data), 32'(v.odat));
        check("tbl_out_sel", 32'(out_sel), 32'(v.osel));
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic r);
        logic       found;
        int         idx;
        logic [3:0] er;
        @(negedge Clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (!found && v[c]) begin
                found = 1'b1;
                idx   = c;
            end
        end
        er = (found && (!m_valid || r)) ? 4'(1 << idx) : 4'b0000;
        check("in_ready", 32'(in_ready), 32'(er));
        @(posedge Clk);
        if (er != 4'b0000) begin
            m_valid = 1'b1;
            m_data  = d[idx*8 +: 8];
            m_sel   = idx;
            m_ptr   = (idx + 1) % 4;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_sel", 32'(out_sel), 32'(m_sel));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Rst_n       = 1'b0;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = 1'b0;
        model_reset();

        //              vld      ordy  rdy      ovld  odat   osel
        tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
        tbl[2]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
        tbl[6]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
        tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
        tbl[10] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[11] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};

        repeat (2) @(posedge Clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_sel", 32'(out_sel), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply_vec(tbl[i]);
        end

        // state left by the table: empty, last word ch0/0x11, pointer at 1
        m_valid = 1'b0;
        m_data  = 8'h11;
        m_sel   = 0;
        m_ptr   = 1;

        // backpressure: load ch1, stall five cycles, then drain+load together
        step(4'b1111, FIX_DATA, 1'b1);
        repeat (5) step(4'b1111, FIX_DATA, 1'b0);
        check("bp_held_sel", 32'(out_sel), 32'd1);
        step(4'b1111, FIX_DATA, 1'b1);
        check("bp_next_sel", 32'(out_sel), 32'd2);

        // drop: ch1 asserts while stalled, withdraws, ch3 then wins
        step(4'b0010, FIX_DATA, 1'b0);
        step(4'b0010, FIX_DATA, 1'b0);
        step(4'b1000, FIX_DATA, 1'b1);
        check("drop_sel", 32'(out_sel), 32'd3);
        step(4'b0000, FIX_DATA, 1'b1);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
        end

        // asynchronous reset between edges while a word is held
        step(4'b1111, FIX_DATA, 1'b1);
        step(4'b1111, FIX_DATA, 1'b1);
        @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_sel", 32'(out_sel), 32'd0);
        model_reset();
        @(negedge Clk);
        in_valid  = '0;
        out_ready = 1'b1;
        @(negedge Clk);
        Rst_n = 1'b1;
        step(4'b1111, FIX_DATA, 1'b1);
        check("arst_ptr_zero_sel", 32'(out_sel), 32'd0);
        step(4'b1111, FIX_DATA, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
